sha256_nonce_search: RTL

Controller that sequences the single-block sha256 compression core through a nonce sweep. It accepts a job of a 480-bit message prefix, a nonce range and a 256-bit target. It issues one 512-bit message per cycle to a pipelined core, tracks in-flight nonces, and compares each returned digest against the target. It reports the first hit in issue order, or exhaustion of the range, and sits between the host register interface and the sha256 core instance.

---
 rtl/sha256_ctrl_pkg.sv | 21 ++
 rtl/sha256_nonce_track.sv | 41 ++++
 rtl/sha256_nonce_search.sv | 123 ++++++++++++
 3 files changed

// File: rtl/sha256_ctrl_pkg.sv
// Shared widths, state encodings and helpers for the sha256 nonce search controller.
package sha256_ctrl_pkg;

  localparam int MSG_W    = 512;
  localparam int PREFIX_W = 480;
  localparam int NONCE_W  = 32;
  localparam int DIGEST_W = 256;
  localparam int COUNT_W  = 33;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t RUN   = 2'd1;
  localparam state_t DRAIN = 2'd2;

  // Reverse byte order of a nonce word (little-endian header field).
  function automatic logic [NONCE_W-1:0] bswap32(input logic [NONCE_W-1:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

endpackage

// File: rtl/sha256_nonce_track.sv
// Delay line of {valid, nonce} matching the sha256 core latency, so each
// returning digest can be paired with the nonce that produced it.
// A synchronous flush drops every in-flight entry.
module sha256_nonce_track
  import sha256_ctrl_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [NONCE_W-1:0] in_nonce,
  output logic               out_valid,
  output logic [NONCE_W-1:0] out_nonce
);

  logic [DEPTH-1:0]   valid_sr;
  logic [NONCE_W-1:0] nonce_sr [DEPTH];

  // Shift the tracking entries one stage per cycle; flush clears the valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_sr[i] <= 1'b0;
        nonce_sr[i] <= '0;
      end
    end else begin
      valid_sr[0] <= in_valid && !flush;
      nonce_sr[0] <= in_nonce;
      for (int i = 1; i < DEPTH; i++) begin
        valid_sr[i] <= valid_sr[i-1] && !flush;
        nonce_sr[i] <= nonce_sr[i-1];
      end
    end
  end

  assign out_valid = valid_sr[DEPTH-1];
  assign out_nonce = nonce_sr[DEPTH-1];

endmodule

// File: rtl/sha256_nonce_search.sv
// Nonce sweep controller for a pipelined single-block sha256 core.
// Issues one message per cycle, pairs returning digests with their nonces,
// and reports the first digest <= target or exhaustion of the range.
// Optional build macro SHA256_NONCE_BSWAP_EN: byte-swap the nonce in core_msg[31:0].
module sha256_nonce_search
  import sha256_ctrl_pkg::*;
#(
  parameter int CORE_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [PREFIX_W-1:0] prefix,
  input  logic [NONCE_W-1:0]  nonce_start,
  input  logic [NONCE_W-1:0]  nonce_end,
  input  logic [DIGEST_W-1:0] target,
  output logic [MSG_W-1:0]    core_msg,
  output logic                core_msg_valid,
  input  logic [DIGEST_W-1:0] core_digest,
  output logic                busy,
  output logic                done,
  output logic                found,
  output logic [NONCE_W-1:0]  found_nonce,
  output logic [DIGEST_W-1:0] found_digest,
  output logic [COUNT_W-1:0]  hash_count
);

  state_t              state;
  logic [PREFIX_W-1:0] prefix_q;
  logic [NONCE_W-1:0]  nonce_q;
  logic [NONCE_W-1:0]  nonce_end_q;
  logic [DIGEST_W-1:0] target_q;

  logic                track_valid;
  logic [NONCE_W-1:0]  track_nonce;
  logic                active;
  logic                hit;
  logic                last_back;
  logic                flush;

  assign active         = (state != IDLE);
  assign busy           = active;
  assign core_msg_valid = (state == RUN);

`ifdef SHA256_NONCE_BSWAP_EN
  assign core_msg = {prefix_q, bswap32(nonce_q)};
`else
  assign core_msg = {prefix_q, nonce_q};
`endif

  // Each nonce is issued exactly once per job, so seeing nonce_end come back
  // identifies the final in-flight digest even for a full 2^32 sweep.
  assign hit       = active && track_valid && (core_digest <= target_q);
  assign last_back = active && track_valid && (track_nonce == nonce_end_q);
  assign flush     = hit || (active && abort);

  sha256_nonce_track #(
    .DEPTH(CORE_LATENCY)
  ) u_track (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (core_msg_valid),
    .in_nonce (nonce_q),
    .out_valid(track_valid),
    .out_nonce(track_nonce)
  );

  // Job FSM: accept a job, walk the nonce range, then resolve on hit, abort or drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      prefix_q     <= '0;
      nonce_q      <= '0;
      nonce_end_q  <= '0;
      target_q     <= '0;
      done         <= 1'b0;
      found        <= 1'b0;
      found_nonce  <= '0;
      found_digest <= '0;
      hash_count   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            prefix_q    <= prefix;
            nonce_q     <= nonce_start;
            nonce_end_q <= nonce_end;
            target_q    <= target;
            hash_count  <= '0;
            found       <= 1'b0;
            state       <= RUN;
          end
        end
        RUN, DRAIN: begin
          if (track_valid) begin
            hash_count <= hash_count + COUNT_W'(1);
          end
          if (hit) begin
            found        <= 1'b1;
            found_nonce  <= track_nonce;
            found_digest <= core_digest;
            done         <= 1'b1;
            state        <= IDLE;
          end else if (abort || last_back) begin
            done  <= 1'b1;
            state <= IDLE;
          end else if (state == RUN) begin
            if (nonce_q == nonce_end_q) begin
              state <= DRAIN;
            end else begin
              nonce_q <= nonce_q + NONCE_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
